uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered, parametrised UART transmitter on the standard mem_in_type/mem_out_type bus.
//  Bus writes are queued in a TX FIFO. A frame engine serialises them onto tx with
//  configurable data width, parity and stop bits. Bus reads return a status word.
//  Sits on the peripheral bus in place of the unbuffered uart_tx.
// PARAMETERS
//  clock_rate  434  clock cycles per bit period (>=2)
//  data_bits   8    data bits per frame, 5..8, LSB first
//  parity      0    0 = none, 1 = odd, 2 = even
//  stop_bits   1    1 or 2 stop bits
//  fifo_depth  16   TX FIFO entries, power of 2, >=2
// PORTS
//  reset     in   1    synchronous, active-low
//  clock     in   1    rising-edge clock
//  uart_in   in   mem_in_type   bus request; uses mem_valid, mem_wstrb, mem_wdata
//  uart_out  out  mem_out_type  bus response; drives mem_ready, mem_error, mem_rdata
//  tx        out  1    serial line, idles high
//  tx_idle   out  1    high when the FIFO is empty and the engine is idle
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - FIFO empty; engine IDLE.
//   - tx=1, tx_idle=1, mem_ready=0, mem_error=0, mem_rdata=0.
//   - Reset mid-frame aborts the frame; tx returns to 1 on the next cycle.
//  Bus write (mem_valid=1, |mem_wstrb=1):
//   - Pushes mem_wdata[data_bits-1:0] into the FIFO.
//   - Response in the next cycle: mem_ready=1 for exactly 1 cycle, mem_rdata=0.
//   - FIFO full: byte dropped, FIFO unchanged, mem_ready=1 with mem_error=1.
//  Bus read (mem_valid=1, mem_wstrb=0):
//   - Next cycle: mem_ready=1, mem_error=0.
//   - mem_rdata[0]=full, [1]=empty, [2]=engine busy, [15:8]=FIFO count.
//   - All other mem_rdata bits are 0.
//  mem_ready=0 in every cycle without a request in the prior cycle.
//  Count range is 0..fifo_depth.
//  Engine FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   - Each state is held for exactly clock_rate cycles per bit.
//   - Bit counter runs 0..clock_rate-1, wraps to 0 on each bit boundary.
//   - IDLE: tx=1. If FIFO not empty, pop the head and go to START on the next cycle.
//   - START: tx=0.
//   - DATA: data_bits bits, LSB first.
//   - PARITY: present only if parity!=0. Odd: XOR of data bits inverted. Even: XOR of data bits.
//   - STOP: tx=1 for stop_bits bit periods, then IDLE.
//   - Back-to-back frames: the next START follows the last STOP bit with 1 idle cycle.
//  Simultaneous push and pop in one cycle: count unchanged. A push to a full FIFO
//   succeeds if a pop happens in the same cycle.
//  tx is driven from a register (no combinational path from the bus).
//  tx_idle = FIFO empty && state==IDLE, registered.
// TESTING
//  - data_bits=8, parity=0, stop_bits=1, clock_rate=4: write 0x55 ->
//    tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; tx_idle re-asserts.
//  - parity=2 (even): write 0x07 -> parity bit 1. parity=1 (odd): write 0x07 -> parity bit 0.
//    stop_bits=2 -> 2 stop periods.
//  - fifo_depth=4: write 6 bytes in consecutive cycles ->
//    writes 1-5 mem_error=0 (the 1st byte is popped into the engine);
//    write 6 mem_error=1; transmitted order matches write order.
//  - Status read after 3 queued writes: mem_rdata[15:8] shows the count, bit2=1;
//    after all frames finish, rdata=0x2.
//  - Assert reset mid DATA state -> tx=1 and count=0 next cycle;
//    the next write transmits a clean frame.
//  - data_bits=5: write 0xFF -> only 5 data bits are sent; the frame is 7 bit periods long.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-attached UART transmitter with a TX FIFO and a configurable frame engine
package uart_tx_fifo_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;
    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int clock_rate = 434,
    parameter int data_bits  = 8,
    parameter int parity     = 0,
    parameter int stop_bits  = 1,
    parameter int fifo_depth = 16
) (
    input  logic        reset,
    input  logic        clock,
    input  mem_in_type  uart_in,
    output mem_out_type uart_out,
    output logic        tx,
    output logic        tx_idle
);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = $clog2(clock_rate);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic [data_bits-1:0] fifo_q [fifo_depth];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] count_q, count_d;
    state_t state_q;
    logic [CW-1:0] baud_q;
    logic [2:0] bit_q;
    logic [data_bits-1:0] shift_q;
    logic par_q, tx_q, idle_q, ready_q, error_q;
    logic [31:0] rdata_q;
    logic wr_req, rd_req, pop, push, full, bit_end;
    logic unused;
    assign wr_req  = uart_in.mem_valid && |uart_in.mem_wstrb;
    assign rd_req  = uart_in.mem_valid && !(|uart_in.mem_wstrb);
    assign full    = count_q == (AW+1)'(fifo_depth);
    assign pop     = state_q == IDLE && count_q != '0;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push    = wr_req && (!full || pop);
    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign bit_end = baud_q == CW'(clock_rate - 1);
    assign unused  = &{1'b0, uart_in};
    always_ff @(posedge clock)
        if (push) fifo_q[wr_q] <= uart_in.mem_wdata[data_bits-1:0];
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            idle_q  <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            count_q <= count_d;
            idle_q  <= count_q == '0 && state_q == IDLE;
            ready_q <= uart_in.mem_valid;
            error_q <= wr_req && !push;
            rdata_q <= rd_req ? {16'b0, 8'(count_q), 5'b0, state_q != IDLE, count_q == '0, full} : 32'b0;
            baud_q  <= (state_q == IDLE || bit_end) ? '0 : baud_q + CW'(1);
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= START;
                    tx_q    <= 1'b0;
                    shift_q <= fifo_q[rd_q];
                    par_q   <= (parity == 1) ^ (^fifo_q[rd_q]);
                end
                START: if (bit_end) begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                    bit_q   <= '0;
                end
                DATA: if (bit_end) begin
                    if (bit_q == 3'(data_bits - 1)) begin
                        state_q <= parity != 0 ? PARITY : STOP;
                        tx_q    <= parity != 0 ? par_q : 1'b1;
                        bit_q   <= '0;
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        tx_q    <= shift_q[1];
                        shift_q <= shift_q >> 1;
                    end
                end
                PARITY: if (bit_end) begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: if (bit_end) begin
                    if (bit_q == 3'(stop_bits - 1)) state_q <= IDLE;
                    else bit_q <= bit_q + 3'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign tx                 = tx_q;
    assign tx_idle            = idle_q;
    assign uart_out.mem_ready = ready_q;
    assign uart_out.mem_error = error_q;
    assign uart_out.mem_rdata = rdata_q;
endmodule
